// File: rtl/gte_ir_clamp_seq.sv
// rtl/gte_ir_clamp_seq.sv - GTE MAC1..3 to IR1..3 clamp sequencer with one shared saturation stage
module gte_ir_clamp_seq #(
  parameter int INW   = 32,
  parameter int OUTW  = 16,
  parameter int SHIFT = 12
) (
  input  logic            i_clk,
  input  logic            i_nRst,
  input  logic            i_start,
  input  logic            i_sf,
  input  logic            i_lm,
  input  logic [2:0]      i_chanEn,
  input  logic [INW-1:0]  i_mac1,
  input  logic [INW-1:0]  i_mac2,
  input  logic [INW-1:0]  i_mac3,
  input  logic            i_flagClr,
  output logic            o_busy,
  output logic            o_done,
  output logic [OUTW-1:0] o_ir1,
  output logic [OUTW-1:0] o_ir2,
  output logic [OUTW-1:0] o_ir3,
  output logic [2:0]      o_flag
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CH1  = 2'd1;
  localparam logic [1:0] CH2  = 2'd2;
  localparam logic [1:0] CH3  = 2'd3;

  localparam logic signed [INW-1:0] HI_FULL = {{(INW-OUTW+1){1'b0}}, {(OUTW-1){1'b1}}};
  localparam logic signed [INW-1:0] LO_FULL = {{(INW-OUTW+1){1'b1}}, {(OUTW-1){1'b0}}};
  localparam logic [OUTW-1:0]       HI_OUT  = {1'b0, {(OUTW-1){1'b1}}};
  localparam logic [OUTW-1:0]       LO_OUT  = {1'b1, {(OUTW-1){1'b0}}};

  logic [1:0]      state_q, state_d;
  logic [INW-1:0]  mac1_q, mac1_d, mac2_q, mac2_d, mac3_q, mac3_d;
  logic            sf_q, sf_d, lm_q, lm_d;
  // Channel 1 is only needed to pick the first state, so only bits 2:1 are held.
  logic [2:1]      en_q, en_d;
  logic            done_q, done_d;
  logic [OUTW-1:0] ir1_q, ir1_d, ir2_q, ir2_d, ir3_q, ir3_d;
  logic [2:0]      flag_q, flag_d;

  logic signed [INW-1:0] mac_sel, v, lo;
  logic [OUTW-1:0]       clamp_res;
  logic                  sat;

  always_comb begin
    case (state_q)
      CH1:     mac_sel = mac1_q;
      CH2:     mac_sel = mac2_q;
      CH3:     mac_sel = mac3_q;
      default: mac_sel = '0;
    endcase
    v  = sf_q ? (mac_sel >>> SHIFT) : mac_sel;
    lo = lm_q ? '0 : LO_FULL;
    if (v > HI_FULL) begin
      clamp_res = HI_OUT;
      sat       = 1'b1;
    end else if (v < lo) begin
      clamp_res = lm_q ? '0 : LO_OUT;
      sat       = 1'b1;
    end else begin
      clamp_res = v[OUTW-1:0];
      sat       = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    mac1_d  = mac1_q;
    mac2_d  = mac2_q;
    mac3_d  = mac3_q;
    sf_d    = sf_q;
    lm_d    = lm_q;
    en_d    = en_q;
    done_d  = 1'b0;
    ir1_d   = ir1_q;
    ir2_d   = ir2_q;
    ir3_d   = ir3_q;
    flag_d  = i_flagClr ? 3'b000 : flag_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          mac1_d = i_mac1;
          mac2_d = i_mac2;
          mac3_d = i_mac3;
          sf_d   = i_sf;
          lm_d   = i_lm;
          en_d   = i_chanEn[2:1];
          if (i_chanEn[0])      state_d = CH1;
          else if (i_chanEn[1]) state_d = CH2;
          else if (i_chanEn[2]) state_d = CH3;
          else                  done_d  = 1'b1;
        end
      end
      CH1: begin
        ir1_d     = clamp_res;
        flag_d[0] = flag_d[0] | sat;
        if (en_q[1])      state_d = CH2;
        else if (en_q[2]) state_d = CH3;
        else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      CH2: begin
        ir2_d     = clamp_res;
        flag_d[1] = flag_d[1] | sat;
        if (en_q[2]) state_d = CH3;
        else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        ir3_d     = clamp_res;
        flag_d[2] = flag_d[2] | sat;
        state_d   = IDLE;
        done_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_nRst) begin
      state_q <= IDLE;
      mac1_q  <= '0;
      mac2_q  <= '0;
      mac3_q  <= '0;
      sf_q    <= 1'b0;
      lm_q    <= 1'b0;
      en_q    <= '0;
      done_q  <= 1'b0;
      ir1_q   <= '0;
      ir2_q   <= '0;
      ir3_q   <= '0;
      flag_q  <= '0;
    end else begin
      state_q <= state_d;
      mac1_q  <= mac1_d;
      mac2_q  <= mac2_d;
      mac3_q  <= mac3_d;
      sf_q    <= sf_d;
      lm_q    <= lm_d;
      en_q    <= en_d;
      done_q  <= done_d;
      ir1_q   <= ir1_d;
      ir2_q   <= ir2_d;
      ir3_q   <= ir3_d;
      flag_q  <= flag_d;
    end
  end

  assign o_busy = (state_q != IDLE);
  assign o_done = done_q;
  assign o_ir1  = ir1_q;
  assign o_ir2  = ir2_q;
  assign o_ir3  = ir3_q;
  assign o_flag = flag_q;

endmodule
